hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 38 +++
 rtl/hz_scoreboard.sv | 105 ++++++++++
 rtl/hazard_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: latency defaults,
// register index type, enable-vector bit positions and the per-cycle event kind.
package pipe_ctrl_pkg;

    localparam int INT_LAT_DEF = 4;
    localparam int FP_LAT_DEF  = 6;
    localparam int NREG_DEF    = 8;
    localparam int CNT_W       = 3;

    typedef logic [2:0]       reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // int_we bit positions (ID_EX is the pipe head)
    localparam int IW_ID_EX   = 0;
    localparam int IW_EX_WBTL = 1;
    localparam int IW_WBTL_C  = 2;
    localparam int IW_C_WB    = 3;
    localparam int INT_STAGES = 4;

    // fp_we bit positions (D_F1 is the pipe head)
    localparam int FW_D_F1    = 0;
    localparam int FW_F1_F2   = 1;
    localparam int FW_F2_F3   = 2;
    localparam int FW_F3_F4   = 3;
    localparam int FW_F4_F5   = 4;
    localparam int FW_F5_WB   = 5;
    localparam int FP_STAGES  = 6;

    // What the controller does with the ID instruction this cycle
    typedef enum logic [2:0] {
        EV_FROZEN,
        EV_FLUSH,
        EV_IDLE,
        EV_STALL,
        EV_ISSUE
    } ev_t;

endpackage

// File: rtl/hz_scoreboard.sv
// Register scoreboard and write-port reservation table for hazard_ctrl.
// Per register: countdown to register-file write (and, with HAZ_FWD_EN,
// the producer pipe). Write port: one reservation bit per future cycle plus
// a parallel owner bit that selects which pipe drives the port.
// Optional build macro: HAZ_FWD_EN (integer results forwarded from C stage).
module hz_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int INT_LAT = INT_LAT_DEF,
    parameter int FP_LAT  = FP_LAT_DEF,
    parameter int NREG    = NREG_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     adv,
    input  logic     ins_en,
    input  logic     id_is_fp,
    input  reg_idx_t id_rs_a,
    input  reg_idx_t id_rs_b,
    input  logic     id_use_a,
    input  logic     id_use_b,
    input  reg_idx_t id_rd,
    input  logic     id_wr,
    output logic     hz_raw,
    output logic     hz_waw,
    output logic     hz_slot,
    output logic     wb_fp_sel
);

    localparam cnt_t INT_L = cnt_t'(INT_LAT);
    localparam cnt_t FP_L  = cnt_t'(FP_LAT);
    // An FP write always lands beyond every existing reservation, so only an
    // integer issue can meet an occupied slot.
    localparam int   SLOT_CHK      = (INT_LAT < FP_LAT) ? INT_LAT : FP_LAT - 1;
    localparam logic INT_CAN_CLASH = (INT_LAT < FP_LAT) ? 1'b1 : 1'b0;

    cnt_t              cnt_q [NREG];
    logic [FP_LAT-1:0] slot_q;
    logic [FP_LAT-1:0] owner_q;
    cnt_t              own_lat;
    cnt_t              slot_idx;
`ifdef HAZ_FWD_EN
    logic [NREG-1:0]   fp_q;
`endif

    function automatic cnt_t cnt_dec(input cnt_t c);
        return (c == '0) ? c : c - cnt_t'(1);
    endfunction

    // A source is unsafe until its producer writes this cycle (write-first file)
    function automatic logic src_busy(input reg_idx_t r);
`ifdef HAZ_FWD_EN
        if (fp_q[r])
            return cnt_q[r] > cnt_t'(1);
        else
            return cnt_q[r] > (INT_L - cnt_t'(1));
`else
        return cnt_q[r] > cnt_t'(1);
`endif
    endfunction

    assign own_lat   = id_is_fp ? FP_L : INT_L;
    assign slot_idx  = own_lat - cnt_t'(1);
    assign hz_raw    = (id_use_a & src_busy(id_rs_a)) | (id_use_b & src_busy(id_rs_b));
    assign hz_waw    = id_wr & (cnt_q[id_rd] >= own_lat);
    assign hz_slot   = id_wr & ~id_is_fp & INT_CAN_CLASH & slot_q[SLOT_CHK];
    assign wb_fp_sel = owner_q[0];

    // Countdowns tick on every unfrozen cycle; an issue reloads its destination
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
        end else if (adv) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_dec(cnt_q[r]);
            if (ins_en && id_wr) cnt_q[id_rd] <= own_lat;
        end
    end

`ifdef HAZ_FWD_EN
    // Producer pipe of the most recent write to each register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp_q <= '0;
        end else if (adv && ins_en && id_wr) begin
            fp_q[id_rd] <= id_is_fp;
        end
    end
`endif

    // Reservation and owner bits walk toward index 0, the write cycle itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            owner_q <= '0;
        end else if (adv) begin
            slot_q  <= slot_q >> 1;
            owner_q <= owner_q >> 1;
            if (ins_en && id_wr) begin
                slot_q[slot_idx]  <= 1'b1;
                owner_q[slot_idx] <= id_is_fp;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Issue/stall/flush controller for a dual (integer + FP) pipeline sharing one
// register-file write port. Decides each cycle, combinationally, whether the
// ID instruction issues, stalls, is flushed, or everything freezes.
// Optional build macro: HAZ_FWD_EN (integer RAW relaxed by C-stage forwarding).
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INT_LAT = INT_LAT_DEF,
    parameter int FP_LAT  = FP_LAT_DEF,
    parameter int NREG    = NREG_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_is_fp,
    input  logic [2:0]            id_rs_a,
    input  logic [2:0]            id_rs_b,
    input  logic                  id_use_a,
    input  logic                  id_use_b,
    input  logic [2:0]            id_rd,
    input  logic                  id_wr,
    input  logic                  mem_stall,
    input  logic                  br_flush,
    output logic                  pc_we,
    output logic                  if_id_we,
    output logic [INT_STAGES-1:0] int_we,
    output logic [FP_STAGES-1:0]  fp_we,
    output logic                  id_ex_bubble,
    output logic                  d_f1_bubble,
    output logic                  if_id_flush,
    output logic                  wb_fp_sel,
    output logic [15:0]           stall_cnt
);

    logic flush_pend;
    logic flush_now;
    logic hz_raw, hz_waw, hz_slot, hazard;
    logic issue;
    logic sb_wb_fp;
    ev_t  ev;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    hz_scoreboard #(
        .INT_LAT (INT_LAT),
        .FP_LAT  (FP_LAT),
        .NREG    (NREG)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (~mem_stall),
        .ins_en    (issue),
        .id_is_fp  (id_is_fp),
        .id_rs_a   (id_rs_a),
        .id_rs_b   (id_rs_b),
        .id_use_a  (id_use_a),
        .id_use_b  (id_use_b),
        .id_rd     (id_rd),
        .id_wr     (id_wr),
        .hz_raw    (hz_raw),
        .hz_waw    (hz_waw),
        .hz_slot   (hz_slot),
        .wb_fp_sel (sb_wb_fp)
    );

    assign flush_now = br_flush | flush_pend;
    assign hazard    = hz_raw | hz_waw | hz_slot;
    assign issue     = (ev == EV_ISSUE);

    // Event priority: freeze, then flush, then empty ID, then hazard, else issue
    always_comb begin
        ev = EV_ISSUE;
        if (mem_stall)      ev = EV_FROZEN;
        else if (flush_now) ev = EV_FLUSH;
        else if (!id_valid) ev = EV_IDLE;
        else if (hazard)    ev = EV_STALL;
    end

    // Enable/bubble decode; every pipe register moves unless frozen or in reset
    always_comb begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        int_we       = '0;
        fp_we        = '0;
        id_ex_bubble = 1'b0;
        d_f1_bubble  = 1'b0;
        if_id_flush  = 1'b0;
        wb_fp_sel    = rst_n & sb_wb_fp;
        if (rst_n && ev != EV_FROZEN) begin
            int_we[IW_ID_EX]   = 1'b1;
            int_we[IW_EX_WBTL] = 1'b1;
            int_we[IW_WBTL_C]  = 1'b1;
            int_we[IW_C_WB]    = 1'b1;
            fp_we[FW_D_F1]     = 1'b1;
            fp_we[FW_F1_F2]    = 1'b1;
            fp_we[FW_F2_F3]    = 1'b1;
            fp_we[FW_F3_F4]    = 1'b1;
            fp_we[FW_F4_F5]    = 1'b1;
            fp_we[FW_F5_WB]    = 1'b1;
            unique case (ev)
                EV_FLUSH: begin
                    pc_we        = 1'b1;
                    if_id_we     = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    d_f1_bubble  = 1'b1;
                end
                EV_IDLE: begin
                    pc_we        = 1'b1;
                    if_id_we     = 1'b1;
                    id_ex_bubble = 1'b1;
                    d_f1_bubble  = 1'b1;
                end
                EV_STALL: begin
                    id_ex_bubble = 1'b1;
                    d_f1_bubble  = 1'b1;
                end
                EV_ISSUE: begin
                    pc_we        = 1'b1;
                    if_id_we     = 1'b1;
                    id_ex_bubble = id_is_fp;
                    d_f1_bubble  = ~id_is_fp;
                end
                default: ;
            endcase
        end
    end

    // A flush seen while frozen is held until the pipeline can move again
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
        end else if (mem_stall) begin
            flush_pend <= flush_pend | br_flush;
        end else begin
            flush_pend <= 1'b0;
        end
    end

    // Count hazard-stalled cycles, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (ev == EV_STALL) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
